// File: rtl/config_net_injector.sv
// config_net injector: root transmitter of a config_net tree.
// Serializes (id, data) requests into the framed cfg_bit stream and
// emits a run of ones after every reset so downstream nodes can resync.

package config_net_pkg;
    typedef struct packed {
        logic cfg_clk;
        logic cfg_bit;
    } config_s;
endpackage

module config_net_injector
    import config_net_pkg::*;
#(
    parameter int id_width_p   = 8,
    parameter int data_width_p = 32,
    parameter int frame_len_p  = 8,
    parameter int sync_len_p   = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    valid_i,
    input  logic [id_width_p-1:0]   id_i,
    input  logic [data_width_p-1:0] data_i,
    output logic                    ready_o,
    output config_s                 config_o
);

    // Counters must hold the largest field length (the data bit counter
    // reaches data_width_p itself before the stop decision).
    localparam int max_ab_lp = (id_width_p > data_width_p) ? id_width_p : data_width_p;
    localparam int max_cd_lp = (frame_len_p > sync_len_p) ? frame_len_p : sync_len_p;
    localparam int max_lp    = (max_ab_lp > max_cd_lp) ? max_ab_lp : max_cd_lp;
    localparam int cnt_w_lp  = $clog2(max_lp) + 1;
    localparam int sh_w_lp   = id_width_p + data_width_p;

    localparam logic [cnt_w_lp-1:0] sync_last_lp  = cnt_w_lp'(sync_len_p - 1);
    localparam logic [cnt_w_lp-1:0] id_last_lp    = cnt_w_lp'(id_width_p - 1);
    localparam logic [cnt_w_lp-1:0] frame_last_lp = cnt_w_lp'(frame_len_p - 1);
    localparam logic [cnt_w_lp-1:0] data_len_lp   = cnt_w_lp'(data_width_p);

    typedef enum logic [2:0] {
        S_SYNC,
        S_IDLE,
        S_ID,
        S_DATA,
        S_FRAME,
        S_STOP
    } state_e;

    state_e                state_r;
    logic                  cfg_bit_r;
    logic [cnt_w_lp-1:0]   sync_cnt_r;
    logic [cnt_w_lp-1:0]   bit_cnt_r;
    logic [cnt_w_lp-1:0]   frame_cnt_r;
    logic [sh_w_lp-1:0]    shift_r;

    // The state register is the only thing ready_o looks at.
    assign ready_o = (state_r == S_IDLE);

    assign config_o.cfg_clk = clk_i;
    assign config_o.cfg_bit = cfg_bit_r;

    // Serializer FSM: each state decides the bit loaded on the next edge.
    // S_STOP holds the last framing bit on the wire and then loads the stop '1'.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r     <= S_SYNC;
            cfg_bit_r   <= 1'b1;
            sync_cnt_r  <= '0;
            bit_cnt_r   <= '0;
            frame_cnt_r <= '0;
            shift_r     <= '0;
        end else begin
            case (state_r)
                S_SYNC: begin
                    cfg_bit_r <= 1'b1;
                    if (sync_cnt_r == sync_last_lp) begin
                        sync_cnt_r <= '0;
                        state_r    <= S_IDLE;
                    end else begin
                        sync_cnt_r <= sync_cnt_r + 1'b1;
                    end
                end
                S_IDLE: begin
                    cfg_bit_r <= 1'b1;
                    if (valid_i) begin
                        // Start bit goes out now; payload is held internally.
                        shift_r   <= {data_i, id_i};
                        cfg_bit_r <= 1'b0;
                        bit_cnt_r <= '0;
                        state_r   <= S_ID;
                    end
                end
                S_ID: begin
                    cfg_bit_r <= shift_r[0];
                    shift_r   <= shift_r >> 1;
                    if (bit_cnt_r == id_last_lp) begin
                        bit_cnt_r   <= '0;
                        frame_cnt_r <= '0;
                        state_r     <= S_DATA;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 1'b1;
                    end
                end
                S_DATA: begin
                    cfg_bit_r <= shift_r[0];
                    shift_r   <= shift_r >> 1;
                    bit_cnt_r <= bit_cnt_r + 1'b1;
                    if (frame_cnt_r == frame_last_lp) begin
                        frame_cnt_r <= '0;
                        state_r     <= S_FRAME;
                    end else begin
                        frame_cnt_r <= frame_cnt_r + 1'b1;
                    end
                end
                S_FRAME: begin
                    // Framing '0' after every group, the last group included.
                    cfg_bit_r <= 1'b0;
                    if (bit_cnt_r == data_len_lp) begin
                        bit_cnt_r <= '0;
                        state_r   <= S_STOP;
                    end else begin
                        state_r <= S_DATA;
                    end
                end
                S_STOP: begin
                    cfg_bit_r <= 1'b1;
                    state_r   <= S_IDLE;
                end
                default: begin
                    cfg_bit_r <= 1'b1;
                    state_r   <= S_SYNC;
                end
            endcase
        end
    end

endmodule
